// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
//
// Shares the single register-file write port among NUM_REQ writeback
// sources (index 0 is the ALU) with a round-robin arbiter. It also keeps a
// pending-write scoreboard so decode can stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   req_valid/addr/data per-requester write requests (packed, i at [i*W +: W])
//   req_ready           one-hot grant; a request transfers on valid && ready
//   issue_valid/addr    decode reserves a destination register
//   issue_ready         reservation can be accepted this cycle
//   chk_addr_1/2        source registers to check
//   busy_1/2            source register has a pending write
//   rf_wr_enable/addr/data  register file write port (registered, latency 1)

module rf_writeback_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int NUM_OF_SETS    = 32,
    parameter int DATA_BUS_WIDTH = 32,
    localparam int AW            = $clog2(NUM_OF_SETS),
    localparam int PW            = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*AW-1:0]             req_addr,
    input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic                              issue_valid,
    input  logic [AW-1:0]                     issue_addr,
    output logic                              issue_ready,
    input  logic [AW-1:0]                     chk_addr_1,
    input  logic [AW-1:0]                     chk_addr_2,
    output logic                              busy_1,
    output logic                              busy_2,
    output logic                              rf_wr_enable,
    output logic [AW-1:0]                     rf_wr_addr,
    output logic [DATA_BUS_WIDTH-1:0]         rf_wr_data
);

    logic [PW-1:0]             ptr_q;
    logic [PW-1:0]             cand;
    logic [PW-1:0]             grant_idx;
    logic                      grant_any;
    logic [AW-1:0]             grant_addr;
    logic [DATA_BUS_WIDTH-1:0] grant_data;

    logic [NUM_OF_SETS-1:0]    pending_q;
    logic [NUM_OF_SETS-1:0]    pending_d;
    logic [NUM_OF_SETS-1:0]    set_vec;
    logic [NUM_OF_SETS-1:0]    clr_vec;

    // Requester index 'off' positions after 'base', wrapping at NUM_REQ.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PW'(sum);
    endfunction

    // Round-robin pick: first valid requester at or after the pointer.
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = rr_index(ptr_q, off);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_addr = req_addr[grant_idx*AW +: AW];
    assign grant_data = req_data[grant_idx*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];

    // Readiness looks at the pre-clear pending bit, so a register being
    // committed this cycle still stalls a new reservation for one cycle.
    assign issue_ready = (issue_addr == '0) || !pending_q[issue_addr];
    assign busy_1      = (chk_addr_1 != '0) && pending_q[chk_addr_1];
    assign busy_2      = (chk_addr_2 != '0) && pending_q[chk_addr_2];

    // Set is applied after clear so a same-cycle reservation survives the
    // commit of the previous write to that register.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && issue_ready && (issue_addr != '0)) begin
            set_vec[issue_addr] = 1'b1;
        end
        if (rf_wr_enable) begin
            clr_vec[rf_wr_addr] = 1'b1;
        end
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q        <= '0;
            pending_q    <= '0;
            rf_wr_enable <= 1'b0;
            rf_wr_addr   <= '0;
            rf_wr_data   <= '0;
        end else begin
            pending_q <= pending_d;
            if (grant_any) begin
                ptr_q        <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                // x0 writes consume the grant but never reach the register file.
                rf_wr_enable <= (grant_addr != '0);
                rf_wr_addr   <= grant_addr;
                rf_wr_data   <= grant_data;
            end else begin
                rf_wr_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter with a write-port scoreboard.
module tb_rf_writeback_arbiter;

    localparam int NUM_REQ = 3;
    localparam int AW      = 5;
    localparam int DW      = 32;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  issue_valid;
    logic [AW-1:0]         issue_addr;
    logic                  issue_ready;
    logic [AW-1:0]         chk_addr_1;
    logic [AW-1:0]         chk_addr_2;
    logic                  busy_1;
    logic                  busy_2;
    logic                  rf_wr_enable;
    logic [AW-1:0]         rf_wr_addr;
    logic [DW-1:0]         rf_wr_data;

    rf_writeback_arbiter #(
        .NUM_REQ(NUM_REQ),
        .NUM_OF_SETS(32),
        .DATA_BUS_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_ready(req_ready),
        .issue_valid(issue_valid),
        .issue_addr(issue_addr),
        .issue_ready(issue_ready),
        .chk_addr_1(chk_addr_1),
        .chk_addr_2(chk_addr_2),
        .busy_1(busy_1),
        .busy_2(busy_2),
        .rf_wr_enable(rf_wr_enable),
        .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every committed write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rf_wr_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=addr %0h data %0h required=no write",
                             rf_wr_addr, rf_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", DW'(rf_wr_addr), DW'(e.a));
                    check("wr_data", rf_wr_data, e.d);
                end
            end
        end
    end

    logic [2:0] rr_exp [6];
    logic [AW-1:0] rr_a [3];
    logic [DW-1:0] rr_d [3];

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rr_a   = '{5'd5, 5'd6, 5'd7};
        rr_d   = '{32'hA, 32'hB, 32'hC};

        // Reset held two cycles with requests and an issue pending.
        rst         = 1'b0;
        req_valid   = 3'b111;
        req_addr    = '0;
        req_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, rr_a[i], rr_d[i]);
        issue_valid = 1'b1;
        issue_addr  = 5'd3;
        chk_addr_1  = 5'd3;
        chk_addr_2  = 5'd0;
        @(negedge clk);
        #1 check("rst_ready_c1", DW'(req_ready), 32'b001);
        @(negedge clk);
        #1 check("rst_ready_c2", DW'(req_ready), 32'b001);
        check("rst_wr_en", DW'(rf_wr_enable), 32'd0);
        rst         = 1'b1;
        req_valid   = 3'b000;
        issue_valid = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_wr_en", DW'(rf_wr_enable), 32'd0);
        check("post_rst_busy1", DW'(busy_1), 32'd0);
        check("post_rst_busy2", DW'(busy_2), 32'd0);
        check("post_rst_issue_ready", DW'(issue_ready), 32'd1);

        // Round robin, all three requesting for six cycles.
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_grant", DW'(req_ready), DW'(rr_exp[k]));
            if (k > 0) check("rr_wr_en_cont", DW'(rf_wr_enable), 32'd1);
            push_exp(rr_a[k % 3], rr_d[k % 3]);
            @(negedge clk);
        end
        req_valid = 3'b000;

        // Scoreboard: reserve x9, commit it from requester 1 at cycle 4.
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        chk_addr_1  = 5'd9;
        for (int c = 0; c <= 6; c++) begin
            #1;
            if (c == 0) begin
                check("sb_issue_ready_c0", DW'(issue_ready), 32'd1);
                check("sb_busy_c0", DW'(busy_1), 32'd0);
            end else if (c <= 5) begin
                check("sb_issue_ready_stall", DW'(issue_ready), 32'd0);
                check("sb_busy_hold", DW'(busy_1), 32'd1);
            end else begin
                check("sb_issue_ready_c6", DW'(issue_ready), 32'd1);
                check("sb_busy_c6", DW'(busy_1), 32'd0);
            end
            if (c == 4) begin
                check("sb_grant_r1", DW'(req_ready), 32'b010);
                push_exp(5'd9, 32'h1234);
            end
            @(negedge clk);
            issue_valid = 1'b0;
            req_valid   = 3'b000;
            if (c == 3) begin
                set_req(1, 5'd9, 32'h1234);
                req_valid = 3'b010;
            end
        end

        // x0 write from requester 2 (pointer is at 2 now).
        set_req(2, 5'd0, 32'hFFFF_FFFF);
        req_valid   = 3'b100;
        issue_valid = 1'b1;
        issue_addr  = 5'd0;
        chk_addr_1  = 5'd0;
        chk_addr_2  = 5'd0;
        #1;
        check("x0_grant", DW'(req_ready), 32'b100);
        check("x0_issue_ready", DW'(issue_ready), 32'd1);
        @(negedge clk);
        req_valid   = 3'b000;
        issue_valid = 1'b0;
        #1;
        check("x0_no_write", DW'(rf_wr_enable), 32'd0);
        check("x0_busy1", DW'(busy_1), 32'd0);
        check("x0_busy2", DW'(busy_2), 32'd0);
        // Pointer must have advanced to 0: requesters 1,2 valid -> grant 1.
        set_req(1, 5'd0, 32'h0);
        req_valid = 3'b110;
        #1 check("x0_ptr_adv", DW'(req_ready), 32'b010);
        @(negedge clk);
        req_valid = 3'b000;

        // Set/clear collision on x12 (pointer at 2).
        set_req(2, 5'd12, 32'h5A5A);
        req_valid = 3'b100;
        #1 check("col_grant", DW'(req_ready), 32'b100);
        push_exp(5'd12, 32'h5A5A);
        @(negedge clk);
        req_valid   = 3'b000;
        issue_valid = 1'b1;
        issue_addr  = 5'd12;
        chk_addr_2  = 5'd12;
        #1;
        check("col_issue_ready", DW'(issue_ready), 32'd1);
        check("col_busy_before", DW'(busy_2), 32'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        check("col_busy_after", DW'(busy_2), 32'd1);
        check("col_issue_stall", DW'(issue_ready), 32'd0);

        // Reset mid-stream: grant in the reset cycle is dropped.
        set_req(0, 5'd15, 32'h77);
        req_valid   = 3'b001;
        issue_valid = 1'b1;
        issue_addr  = 5'd20;
        chk_addr_1  = 5'd20;
        rst         = 1'b0;
        #1 check("mid_rst_grant", DW'(req_ready), 32'b001);
        @(negedge clk);
        rst         = 1'b1;
        req_valid   = 3'b000;
        issue_valid = 1'b0;
        #1;
        check("mid_rst_no_write", DW'(rf_wr_enable), 32'd0);
        check("mid_rst_pending12", DW'(busy_2), 32'd0);
        check("mid_rst_pending20", DW'(busy_1), 32'd0);
        // Pointer back at 0: requesters 0,1 valid -> grant 0.
        req_valid = 3'b011;
        set_req(1, 5'd4, 32'h44);
        #1 check("mid_rst_ptr", DW'(req_ready), 32'b001);
        push_exp(5'd15, 32'h77);
        @(negedge clk);
        req_valid = 3'b000;
        repeat (3) @(negedge clk);

        mon_en = 1'b0;
        check("queue_empty", DW'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Shares the single write port of the 32-entry register file among NUM_REQ writeback sources: ALU, load unit and mul/div.
- Tracks in-flight destination registers in a scoreboard so decode can detect RAW/WAW hazards and stall.
- Sits between the execute-stage producers and the register file write port (wr_enable, wr_addr, wr_data).

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8); index 0 is ALU.
- NUM_OF_SETS, 32, register count; address width AW = $clog2(NUM_OF_SETS).
- DATA_BUS_WIDTH, 32, write data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*AW  destination addresses, packed; requester i at [i*AW +: AW].
- req_data  input  NUM_REQ*DATA_BUS_WIDTH  write data, packed the same way.
- req_ready  output  NUM_REQ  one-hot grant; the request transfers when valid&&ready.
- issue_valid  input  1  decode reserves a destination register.
- issue_addr  input  AW  destination being reserved.
- issue_ready  output  1  reservation accepted this cycle.
- chk_addr_1, chk_addr_2  input  AW each  source registers to check.
- busy_1, busy_2  output  1 each  source register has a pending write.
- rf_wr_enable  output  1  to register file wr_enable.
- rf_wr_addr  output  AW  to register file wr_addr.
- rf_wr_data  output  DATA_BUS_WIDTH  to register file wr_data.

Behaviour:
- Reset (rst==0 at posedge):
  - rf_wr_enable=0; rf_wr_addr=0; rf_wr_data=0.
  - All pending bits = 0; round-robin pointer = 0.
  - Combinational outputs follow from cleared state: busy_*=0, issue_ready=1.
  - Reset overrides any simultaneous grant or issue. A grant in the reset cycle is not committed, and its data is lost.
- Arbitration (combinational):
  - Round-robin search starting at the pointer. The first i with req_valid[i] gets req_ready[i]=1; all others get 0.
  - At most one grant per cycle. With no valid requests, req_ready=0.
  - Pointer update on a grant to i: pointer <= (i+1) mod NUM_REQ. With no grant, the pointer holds.
  - req_ready never depends on req_ready; it depends only on req_valid and the pointer.
  - Requesters hold valid/addr/data stable until granted; the arbiter does not check this.
- Write path (registered, latency 1): a grant in cycle N produces rf_wr_enable=1 with the granted addr/data in cycle N+1. The register file writes at the end of N+1.
- x0 handling: a granted request to address 0 consumes the grant and advances the pointer, but rf_wr_enable stays 0 in N+1.
- Scoreboard:
  - One pending bit per register. Bit 0 is hard-wired to 0.
  - Set: issue_valid && issue_ready && issue_addr!=0.
  - Clear: at the posedge ending a cycle where rf_wr_enable==1, for bit rf_wr_addr.
  - Simultaneous set and clear of the same bit: set wins (bit stays 1).
  - A write to a non-pending register is committed normally and leaves the scoreboard unchanged.
- issue_ready = (issue_addr==0) || !pending[issue_addr]. This enforces a WAW stall.
  - The check uses the pre-clear pending value (conservative: one extra stall cycle when a clear happens in the same cycle).
  - issue_ready is independent of issue_valid.
- busy_k = (chk_addr_k!=0) && pending[chk_addr_k]. No bypass: busy stays 1 through the commit cycle N+1 and drops in N+2, when the register file already holds the new value.
- Throughput: one committed write per cycle sustained.

Test Plan:
- Reset: hold rst=0 with req_valid=3'b111 and issue_valid=1 for 2 cycles -> req_ready combinationally 3'b001 but nothing committed; after release rf_wr_enable=0, busy_1=busy_2=0, pointer=0.
- Round-robin: req_valid=3'b111 held 6 cycles, addrs 5/6/7, data 0xA/0xB/0xC -> grants 001,010,100,001,010,100; rf_wr_* one cycle later: (5,0xA),(6,0xB),(7,0xC),... with rf_wr_enable continuously 1.
- Scoreboard: issue addr 9 at cycle 0; chk_addr_1=9 -> busy_1=1 from cycle 1; requester 1 writes addr 9 data 0x1234 at cycle 4 -> rf_wr_enable=1 at cycle 5, busy_1=0 at cycle 6; second issue to 9 gives issue_ready=0 in cycles 1-5 and 1 at cycle 6.
- x0: requester 2 writes addr 0 data 0xFFFF_FFFF -> req_ready[2]=1, pointer advances, rf_wr_enable=0 next cycle; issue addr 0 -> issue_ready=1, busy with chk=0 stays 0.
- Set/clear collision: commit to addr 12 in the same cycle a new issue to 12 is accepted (pending not yet set) -> pending[12]=1 afterwards, busy=1.
- Idle/reset mid-stream: grant at cycle N with rst=0 at cycle N -> rf_wr_enable=0 at N+1 and all pending bits cleared.
